// File: rtl/difftest_sched_pkg.sv
// Shared types for the difftest step scheduler.
// States, termination causes and the cause priority helper.
package difftest_sched_pkg;

  typedef enum logic [2:0] {
    INIT,
    RUN,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    FAIL   = 2'd1,
    MAXCYC = 2'd2,
    OVFL   = 2'd3
  } cause_e;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_FAIL   = 2'd1;
  localparam logic [1:0] CAUSE_MAXCYC = 2'd2;
  localparam logic [1:0] CAUSE_OVFL   = 2'd3;

  // checker failure outranks the cycle limit, which outranks overflow
  function automatic cause_e pick_cause(
    input logic f,
    input logic m,
    input logic o
  );
    cause_e c;
    c = NONE;
    if (f)      c = FAIL;
    else if (m) c = MAXCYC;
    else if (o) c = OVFL;
    return c;
  endfunction

endpackage

// File: rtl/difftest_step_acc.sv
// Step delay register and pending-step accumulator.
// Saturates on overflow; also drives dut_stall.
module difftest_step_acc
  import difftest_sched_pkg::*;
#(
  parameter int STEP_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [STEP_WIDTH-1:0] step_in,
  input  logic                  take,
  input  logic [ACC_WIDTH-1:0]  snap,
  input  logic                  done,
`ifdef DIFFTEST_STEP_BATCH_EN
  output logic                  step_idle,
`endif
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovfl,
  output logic                  stall
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [ACC_WIDTH-1:0] STEP_MAX =
    {{(ACC_WIDTH-STEP_WIDTH){1'b0}}, {STEP_WIDTH{1'b1}}};
  localparam logic [ACC_WIDTH-1:0] STALL_AT = ACC_MAX - STEP_MAX;

  logic [STEP_WIDTH-1:0] step_d;
  logic [ACC_WIDTH-1:0]  base;
  logic [ACC_WIDTH:0]    sum;

  always_comb begin
    base = take ? acc - snap : acc;
    sum  = {1'b0, base} +
           {{(ACC_WIDTH+1-STEP_WIDTH){1'b0}}, step_d};
    ovfl = sum[ACC_WIDTH];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      step_d <= '0;
      acc    <= '0;
    end else begin
      step_d <= step_in;
      acc    <= ovfl ? ACC_MAX : sum[ACC_WIDTH-1:0];
    end
  end

  // one more full-width step could wrap, so hold the DUT off
  assign stall = (acc > STALL_AT) || done;

`ifdef DIFFTEST_STEP_BATCH_EN
  assign step_idle = (step_d == '0);
`endif

endmodule

// File: rtl/difftest_step_scheduler.sv
// Batches SimTop steps into host-checker requests.
// DIFFTEST_STEP_BATCH_EN enables batching with idle flush.
module difftest_step_scheduler
  import difftest_sched_pkg::*;
#(
  parameter int STEP_WIDTH    = 8,
  parameter int ACC_WIDTH     = 16
`ifdef DIFFTEST_STEP_BATCH_EN
  ,
  parameter int BATCH_MIN     = 32,
  parameter int FLUSH_TIMEOUT = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [STEP_WIDTH-1:0] step_in,
  input  logic [63:0]           max_cycles,
  output logic                  init_valid,
  input  logic                  init_ready,
  output logic                  req_valid,
  output logic [ACC_WIDTH-1:0]  req_nstep,
  input  logic                  req_ready,
  input  logic                  resp_valid,
  input  logic                  resp_fail,
  output logic                  dut_stall,
  output logic [63:0]           n_cycles,
  output logic                  done,
  output logic [1:0]            done_cause
);

  state_e                 state;
  state_e                 state_nx;
  cause_e                 cause_q;
  logic [ACC_WIDTH-1:0]   snap;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   ovfl;
  logic                   take;
  logic                   issue_cond;
  logic                   fail_hit;
  logic                   max_hit;
  logic                   term;

`ifdef DIFFTEST_STEP_BATCH_EN
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_TIMEOUT);
  localparam logic [ACC_WIDTH-1:0] BATCH = ACC_WIDTH'(BATCH_MIN);

  logic              step_idle;
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n || state != RUN || !step_idle)
      idle_cnt <= '0;
    else if (idle_cnt != IDLE_MAX)
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign issue_cond = (acc >= BATCH) ||
                      (acc != '0 && idle_cnt == IDLE_MAX);
`else
  assign issue_cond = (acc != '0);
`endif

  difftest_step_acc #(
    .STEP_WIDTH (STEP_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clock     (clock),
    .reset_n   (reset_n),
    .step_in   (step_in),
    .take      (take),
    .snap      (snap),
    .done      (state == DONE),
`ifdef DIFFTEST_STEP_BATCH_EN
    .step_idle (step_idle),
`endif
    .acc       (acc),
    .ovfl      (ovfl),
    .stall     (dut_stall)
  );

  always_comb begin
    state_nx   = state;
    init_valid = 1'b0;
    req_valid  = 1'b0;
    take       = 1'b0;
    fail_hit   = (state == WAIT) && resp_valid && resp_fail;
    max_hit    = (max_cycles != '0) && (n_cycles >= max_cycles);
    term       = (state != DONE) && (fail_hit || max_hit || ovfl);
    unique case (state)
      INIT: begin
        init_valid = 1'b1;
        if (init_ready) state_nx = RUN;
      end
      RUN: begin
        if (issue_cond) state_nx = ISSUE;
      end
      ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) begin
          take     = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (resp_valid) state_nx = RUN;
      end
      DONE: state_nx = DONE;
      default: state_nx = INIT;
    endcase
    if (term) state_nx = DONE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= INIT;
      cause_q  <= NONE;
      snap     <= '0;
      n_cycles <= '0;
    end else begin
      state <= state_nx;
      if (state == RUN && state_nx == ISSUE)
        snap <= acc;
      if (term)
        cause_q <= pick_cause(fail_hit, max_hit, ovfl);
      // the terminating cycle is not counted, so n_cycles lands on the limit
      if (state_nx != DONE)
        n_cycles <= n_cycles + 64'd1;
    end
  end

  assign req_nstep  = req_valid ? snap : '0;
  assign done       = (state == DONE);
  assign done_cause = cause_q;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed bench for difftest_step_scheduler.
// Expected values are hand-derived cycle by cycle.
module tb_difftest_step_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  step_in;
  logic [63:0] max_cycles;
  logic        init_valid;
  logic        init_ready;
  logic        req_valid;
  logic [15:0] req_nstep;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_fail;
  logic        dut_stall;
  logic [63:0] n_cycles;
  logic        done;
  logic [1:0]  done_cause;

  int vectors = 0;
  int miscompares = 0;

  difftest_step_scheduler dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .step_in    (step_in),
    .max_cycles (max_cycles),
    .init_valid (init_valid),
    .init_ready (init_ready),
    .req_valid  (req_valid),
    .req_nstep  (req_nstep),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_fail  (resp_fail),
    .dut_stall  (dut_stall),
    .n_cycles   (n_cycles),
    .done       (done),
    .done_cause (done_cause)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] maxc);
    reset_n    = 1'b0;
    step_in    = '0;
    max_cycles = maxc;
    init_ready = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_fail  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset(64'd0);
    vectors++;
    if (n_cycles !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_ncyc got %0d exp 0", n_cycles);
    end
    vectors++;
    if ({done, done_cause} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_done got %0d/%0d exp 0/0",
               done, done_cause);
    end
    vectors++;
    if ({req_valid, dut_stall} !== 2'b00 || req_nstep !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_out got rv=%0d st=%0d n=%0d exp 0",
               req_valid, dut_stall, req_nstep);
    end
  endtask

  task automatic test_init();
    logic bad;
    reset_n = 1'b1;
    tick();
    vectors++;
    if (init_valid !== 1'b1 || n_cycles !== 64'd1) begin
      miscompares++;
      $display("FAIL init_hold got iv=%0d nc=%0d exp 1/1",
               init_valid, n_cycles);
    end
    init_ready = 1'b1;
    tick();
    init_ready = 1'b0;
    vectors++;
    if (init_valid !== 1'b0 || n_cycles !== 64'd2) begin
      miscompares++;
      $display("FAIL init_done got iv=%0d nc=%0d exp 0/2",
               init_valid, n_cycles);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (req_valid !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0 || n_cycles !== 64'd6) begin
      miscompares++;
      $display("FAIL init_idle got bad=%0d nc=%0d exp 0/6",
               bad, n_cycles);
    end
  endtask

  task automatic test_single();
    logic bad;
    req_ready = 1'b1;
    step_in   = 8'd3;
    tick();
    step_in = 8'd0;
    bad = req_valid;
    tick();
    bad = bad | req_valid;
    tick();
    vectors++;
    if (bad !== 1'b0 || req_valid !== 1'b1 || req_nstep !== 16'd3) begin
      miscompares++;
      $display("FAIL single_req got early=%0d rv=%0d n=%0d exp 0/1/3",
               bad, req_valid, req_nstep);
    end
    tick();
    vectors++;
    if (req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_hs got rv=%0d exp 0", req_valid);
    end
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    // a failing response while not waiting must be ignored
    resp_valid = 1'b1;
    resp_fail  = 1'b1;
    tick();
    resp_valid = 1'b0;
    resp_fail  = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b0 || req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_resp got done=%0d rv=%0d exp 0/0",
               done, req_valid);
    end
    req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic bad;
    req_ready = 1'b0;
    step_in   = 8'd5;
    tick();
    step_in = 8'd1;
    tick();
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_nstep !== 16'd5) begin
      miscompares++;
      $display("FAIL bp_first got rv=%0d n=%0d exp 1/5",
               req_valid, req_nstep);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (req_valid !== 1'b1 || req_nstep !== 16'd5) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hold got n=%0d exp 5", req_nstep);
    end
    req_ready = 1'b1;
    step_in   = 8'd0;
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_nstep !== 16'd7) begin
      miscompares++;
      $display("FAIL bp_carry got rv=%0d n=%0d exp 1/7",
               req_valid, req_nstep);
    end
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    req_ready  = 1'b0;
    tick();
    vectors++;
    if (req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain got rv=%0d exp 0", req_valid);
    end
  endtask

  task automatic test_batch();
    int lat;
    int exp_lat;
`ifdef DIFFTEST_STEP_BATCH_EN
    exp_lat = 19;
`else
    exp_lat = 3;
`endif
    req_ready = 1'b1;
    step_in   = 8'd10;
    tick();
    step_in = 8'd0;
    lat = 1;
    while (req_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != exp_lat || req_nstep !== 16'd10) begin
      miscompares++;
      $display("FAIL batch_lat got lat=%0d n=%0d exp %0d/10",
               lat, req_nstep, exp_lat);
    end
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    req_ready  = 1'b0;
    tick();
  endtask

  task automatic test_fail();
    int          lat;
    logic [63:0] pre;
    req_ready = 1'b1;
    step_in   = 8'd2;
    tick();
    step_in = 8'd0;
    lat = 1;
    while (req_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++;
    if (req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fail_req got rv=%0d exp 1 (timeout)", req_valid);
    end
    tick();
    pre = n_cycles;
    resp_valid = 1'b1;
    resp_fail  = 1'b1;
    tick();
    resp_valid = 1'b0;
    resp_fail  = 1'b0;
    vectors++;
    if (done !== 1'b1 || done_cause !== 2'd1) begin
      miscompares++;
      $display("FAIL fail_done got done=%0d cause=%0d exp 1/1",
               done, done_cause);
    end
    vectors++;
    if (dut_stall !== 1'b1 || req_valid !== 1'b0 ||
        init_valid !== 1'b0 || n_cycles !== pre) begin
      miscompares++;
      $display("FAIL fail_outs got st=%0d rv=%0d nc=%0d exp 1/0/%0d",
               dut_stall, req_valid, n_cycles, pre);
    end
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (n_cycles !== pre || done !== 1'b1) begin
      miscompares++;
      $display("FAIL fail_frozen got nc=%0d done=%0d exp %0d/1",
               n_cycles, done, pre);
    end
    req_ready = 1'b0;
  endtask

  task automatic test_max();
    int cnt;
    do_reset(64'd100);
    reset_n    = 1'b1;
    init_ready = 1'b1;
    cnt = 0;
    while (done !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    vectors++;
    if (cnt != 101 || n_cycles !== 64'd100) begin
      miscompares++;
      $display("FAIL max_when got cyc=%0d nc=%0d exp 101/100",
               cnt, n_cycles);
    end
    vectors++;
    if (done_cause !== 2'd2 || dut_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL max_cause got cause=%0d st=%0d exp 2/1",
               done_cause, dut_stall);
    end
  endtask

  task automatic test_same_cycle();
    int lat;
    do_reset(64'd0);
    reset_n    = 1'b1;
    init_ready = 1'b1;
    tick();
    req_ready = 1'b1;
    step_in   = 8'd2;
    tick();
    step_in = 8'd0;
    lat = 1;
    while (req_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    tick();
    max_cycles = n_cycles;
    resp_valid = 1'b1;
    resp_fail  = 1'b1;
    tick();
    resp_valid = 1'b0;
    resp_fail  = 1'b0;
    max_cycles = 64'd0;
    vectors++;
    if (done !== 1'b1 || done_cause !== 2'd1) begin
      miscompares++;
      $display("FAIL prio_fail got done=%0d cause=%0d exp 1/1",
               done, done_cause);
    end
  endtask

  task automatic test_overflow();
    int stall_at;
    int done_at;
    do_reset(64'd0);
    reset_n    = 1'b1;
    init_ready = 1'b1;
    req_ready  = 1'b0;
    step_in    = 8'd255;
    stall_at   = 0;
    done_at    = 0;
    for (int i = 1; i <= 400 && done_at == 0; i++) begin
      tick();
      if (dut_stall === 1'b1 && stall_at == 0) stall_at = i;
      if (done === 1'b1) done_at = i;
    end
    step_in = 8'd0;
    vectors++;
    if (stall_at != 258 || done_at != 259) begin
      miscompares++;
      $display("FAIL ovf_when got stall=%0d done=%0d exp 258/259",
               stall_at, done_at);
    end
    vectors++;
    if (done_cause !== 2'd3 || dut_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_cause got cause=%0d st=%0d exp 3/1",
               done_cause, dut_stall);
    end
  endtask

  initial begin
    test_reset();
    test_init();
`ifndef DIFFTEST_STEP_BATCH_EN
    test_single();
    test_backpressure();
`endif
    test_batch();
    test_fail();
    test_max();
    test_same_cycle();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
